sym_fir_pipe: RTL and testbench
===============================

Name: sym_fir_pipe

Overview:
Parametrised, pipelined, linear-phase (symmetric) signed FIR filter for the AM/BASK demodulation chain. It folds symmetric taps with pre-adders, holds run-time-loadable coefficients, and rounds and saturates the output. Input samples arrive under a valid strobe, so the filter can sit behind decimators or run at a gated sample rate. It replaces the fixed-coefficient, fixed-width, truncating FIR stages.

Parameters:
DATA_W, 8, signed input sample width
OUT_W, 8, signed output sample width
COEF_W, 17, signed coefficient width
TAPS, 15, filter length; must be odd and >= 3; NC = (TAPS+1)/2 unique coefficients
SHIFT, 21, right-shift applied to the accumulator before rounding and saturation; must satisfy 1 <= SHIFT < ACC_W
ACC_W, derived: DATA_W+COEF_W+1+clog2(NC), accumulator width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush of delay line and pipeline; coefficients kept
in_valid  in  1  fir_in carries a new sample this cycle
fir_in  in  DATA_W  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NC)  coefficient index; 0 = outer tap pair, NC-1 = centre tap
coef_data  in  COEF_W  signed coefficient value
out_valid  out  1  fir_out is a new sample this cycle
fir_out  out  OUT_W  signed filtered sample
sat  out  1  fir_out was clipped; qualified by out_valid

Behaviour:
- Reset (rst_n low, asynchronous): delay line, all pipeline registers, coefficients, out_valid, fir_out and sat are cleared to 0.
- Delay line: TAPS x DATA_W registers. It shifts only on edges where in_valid=1, with d[0] <= fir_in. When in_valid=0 it holds its contents.
- Pipeline: 3 register stages after the delay line. The pipeline free-runs with no backpressure, and a valid bit travels with each stage.
  - S1: pre-add p[k] = d[k] + d[TAPS-1-k] for k < NC-1, computed at DATA_W+1 bits with sign extension. The centre term is d[NC-1], sign-extended.
  - S2: products m[k] = p[k] * c[k], signed, DATA_W+COEF_W+1 bits.
  - S3: acc = sum of m[k] at ACC_W bits, so no internal overflow is possible. Then r = (acc + 2^(SHIFT-1)) >>> SHIFT, an arithmetic shift giving round-half-up. Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat = 1 when clipping occurs. Register fir_out, sat and out_valid.
- Latency: for a sample captured on edge E, fir_out reflects that sample's full window after edge E+3, with out_valid=1 for exactly one cycle per accepted sample.
- Between outputs, fir_out and sat hold their last values while out_valid=0.
- Back-to-back in_valid gives one output per cycle. Gaps in in_valid produce identical gaps in out_valid.
- Coefficient write: on an edge with coef_we=1, c[coef_addr] <= coef_data.
  - If coef_addr >= NC, the write is ignored.
  - If a write and an S2 multiply happen on the same edge, S2 uses the pre-write value. The new value applies from the next edge onward.
  - There is no guard against mid-stream updates, so a transient output mix is permitted.
- clr (synchronous, evaluated every edge): zeroes the delay line and all stage valid bits. out_valid is 0 from the next cycle, and fir_out holds its value. clr takes priority over a simultaneous in_valid, which is dropped. A simultaneous coef_we is still performed.
- Reset mid-stream: in-flight samples are discarded, and no out_valid is issued for them after rst_n is released.
- Full-scale behaviour: the only lossy points are the final rounding and the saturation; sat flags every clipped sample.

Test Plan:
1. Impulse: load c[0..7] = 5241, 8226, 16590, 28678, 42095, 54183, 62549, 65535. Drive one sample 127, then zeros, all with in_valid=1. Required: 15 non-trivial outputs in symmetric order. The centre output is round((127*65535)/2^21) = 4. The first output appears 3 edges after capture.
2. Rounding: set only c[7] = 16384 and drive the single sample 64. Required: fir_out = 1 (acc = 2^20, exactly half, rounds up). Repeat with -64: fir_out = 0 (round-half-up toward +inf), sat=0.
3. Saturation with SHIFT=16: set all c = 65535 and hold a DC input of 127. Required: steady fir_out = 127, sat=1. With DC input -128: fir_out = -128, sat=1.
4. Gapped input: in_valid high on alternate cycles for 20 samples. Required: exactly 20 out_valid pulses, each 3 edges after its capture. The outputs match the back-to-back results for the same sample sequence.
5. Coefficient update plus clr: write c[7] = 0 in the same edge as an S2 multiply. Required: that output uses the old c[7], and the next one uses 0. Assert clr together with in_valid. Required: the sample is dropped, out_valid=0 next cycle, and the coefficients are unchanged.
6. Async reset mid-stream: pull rst_n low between clock edges while the pipeline is full. Required: out_valid, fir_out, sat and all coefficients are 0 immediately. No stale out_valid appears after release.

Source files
------------

// File: rtl/sym_fir_pipe.sv
// Symmetric (linear-phase) signed FIR with folded pre-adders, run-time coefficients,
// three-stage pipeline after the delay line, and round-half-up plus saturation at the output.
module sym_fir_pipe #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int COEF_W = 17,
    parameter int TAPS   = 15,
    parameter int SHIFT  = 21,
    localparam int NC    = (TAPS + 1) / 2,
    localparam int AW    = (NC > 1) ? $clog2(NC) : 1,
    localparam int ACC_W = DATA_W + COEF_W + 1 + $clog2(NC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] fir_in,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  fir_out,
    output logic                     sat
);

    localparam int PW = DATA_W + 1;
    localparam int MW = DATA_W + COEF_W + 1;
    localparam logic [AW:0]             NC_A = (AW + 1)'(NC);
    localparam logic [ACC_W:0]          HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0]   MAXV = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0]   MINV = ~MAXV;

    logic signed [DATA_W-1:0] r_dly_p0 [TAPS];
    logic                     r_vld_p0;
    logic signed [COEF_W-1:0] r_coef   [NC];
    logic signed [PW-1:0]     r_pre_p1 [NC];
    logic                     r_vld_p1;
    logic signed [MW-1:0]     r_mul_p2 [NC];
    logic                     r_vld_p2;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W:0]    w_rnd;

    // One extra guard bit keeps the half-LSB addition from wrapping near full scale.
    function automatic logic signed [ACC_W:0] f_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] t;
        t = {acc[ACC_W-1], acc} + HALF;
        return t >>> SHIFT;
    endfunction

    function automatic logic f_clip(input logic signed [ACC_W:0] r);
        return (r > MAXV) || (r < MINV);
    endfunction

    function automatic logic signed [OUT_W-1:0] f_sat(input logic signed [ACC_W:0] r);
        if (r > MAXV) return MAXV[OUT_W-1:0];
        if (r < MINV) return MINV[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

    // Delay line: advances only on accepted samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) r_dly_p0[k] <= '0;
            r_vld_p0 <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < TAPS; k++) r_dly_p0[k] <= '0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= in_valid;
            if (in_valid) begin
                r_dly_p0[0] <= fir_in;
                for (int k = 1; k < TAPS; k++) r_dly_p0[k] <= r_dly_p0[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NC; k++) r_coef[k] <= '0;
        end else if (coef_we && ({1'b0, coef_addr} < NC_A)) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // S1: fold symmetric taps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NC; k++) r_pre_p1[k] <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= r_vld_p0 & ~clr;
            for (int k = 0; k < NC - 1; k++)
                r_pre_p1[k] <= {r_dly_p0[k][DATA_W-1], r_dly_p0[k]}
                             + {r_dly_p0[TAPS-1-k][DATA_W-1], r_dly_p0[TAPS-1-k]};
            r_pre_p1[NC-1] <= {r_dly_p0[NC-1][DATA_W-1], r_dly_p0[NC-1]};
        end
    end

    // S2: coefficient multiply; a same-edge coefficient write is seen from the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NC; k++) r_mul_p2[k] <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1 & ~clr;
            for (int k = 0; k < NC; k++)
                r_mul_p2[k] <= $signed({{COEF_W{r_pre_p1[k][PW-1]}}, r_pre_p1[k]})
                             * $signed({{PW{r_coef[k][COEF_W-1]}}, r_coef[k]});
        end
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NC; k++)
            w_acc = w_acc + {{(ACC_W-MW){r_mul_p2[k][MW-1]}}, r_mul_p2[k]};
        w_rnd = f_round(w_acc);
    end

    // S3: accumulate, round, saturate; output data holds between valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fir_out   <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= r_vld_p2 & ~clr;
            if (r_vld_p2 && !clr) begin
                fir_out <= f_sat(w_rnd);
                sat     <= f_clip(w_rnd);
            end
        end
    end

endmodule

// File: tb/tb_sym_fir_pipe.sv
// Directed bench for sym_fir_pipe: two instances (SHIFT=21 and SHIFT=16) share all inputs.
module tb_sym_fir_pipe;
    localparam int TAPS = 15;
    localparam int NC   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [7:0]  fir_in = '0;
    logic               coef_we = 1'b0;
    logic [2:0]         coef_addr = '0;
    logic signed [16:0] coef_data = '0;
    logic               a_vld, a_sat, b_vld, b_sat;
    logic signed [7:0]  a_out, b_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int qa[$], qs[$], qc[$], qb[$], qbs[$];
    int hc[8];
    int imp_c[8] = '{5241, 8226, 16590, 28678, 42095, 54183, 62549, 65535};

    always #5 clk = ~clk;

    sym_fir_pipe #(.SHIFT(21)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .fir_in(fir_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(a_vld), .fir_out(a_out), .sat(a_sat)
    );

    sym_fir_pipe #(.SHIFT(16)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .fir_in(fir_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(b_vld), .fir_out(b_out), .sat(b_sat)
    );

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        if (a_vld) begin qa.push_back(int'(a_out)); qs.push_back(int'(a_sat)); qc.push_back(cyc); end
        if (b_vld) begin qb.push_back(int'(b_out)); qbs.push_back(int'(b_sat)); end
    endtask

    task automatic clear_q();
        qa.delete(); qs.delete(); qc.delete(); qb.delete(); qbs.delete();
    endtask

    task automatic send(input int s);
        in_valid = 1'b1; fir_in = 8'(s);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic load(input int c[8]);
        for (int i = 0; i < NC; i++) begin
            coef_we = 1'b1; coef_addr = 3'(i); coef_data = 17'(c[i]);
            tick();
        end
        coef_we = 1'b0;
        hc = c;
    endtask

    task automatic flush();
        clr = 1'b1; tick(); clr = 1'b0;
        clear_q();
    endtask

    // Direct-form reference for SHIFT=21 with zero history before x[0].
    function automatic int model(input int x[20], input int n);
        longint acc, r;
        acc = 0;
        for (int k = 0; k < TAPS; k++)
            if (n - k >= 0) acc += longint'(hc[(k < NC) ? k : TAPS - 1 - k]) * longint'(x[n-k]);
        r = (acc + (longint'(1) <<< 20)) >>> 21;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        in_valid = 1'b1; fir_in = 8'sd100;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", a_vld); end
        checks++; if (a_out !== 8'sd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", a_out); end
        checks++; if (a_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", a_sat); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        clear_q();
        idle(5);
        checks++; if (qa.size() !== 0) begin failures++; $display("FAIL reset_idle_pulses got=%0d exp=0", qa.size()); end
    endtask

    task automatic test_impulse();
        int exp_imp[15] = '{0, 0, 1, 2, 3, 3, 4, 4, 4, 3, 3, 2, 1, 0, 0};
        int cap;
        load(imp_c);
        flush();
        send(127);
        cap = cyc;
        repeat (14) send(0);
        idle(5);
        checks++; if (qa.size() !== 15) begin failures++; $display("FAIL impulse_count got=%0d exp=15", qa.size()); end
        if (qa.size() == 15) begin
            checks++; if (qc[0] !== cap + 3) begin failures++; $display("FAIL impulse_latency got=%0d exp=%0d", qc[0], cap + 3); end
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (qa[i] !== exp_imp[i]) begin failures++; $display("FAIL impulse_out[%0d] got=%0d exp=%0d", i, qa[i], exp_imp[i]); end
            end
        end
    endtask

    task automatic test_rounding();
        int c[8] = '{0, 0, 0, 0, 0, 0, 0, 16384};
        load(c);
        flush();
        send(64);
        repeat (7) send(0);
        idle(5);
        checks++; if (qa.size() !== 8) begin failures++; $display("FAIL round_pos_count got=%0d exp=8", qa.size()); end
        if (qa.size() == 8) begin
            checks++; if (qa[0] !== 0) begin failures++; $display("FAIL round_pos_first got=%0d exp=0", qa[0]); end
            checks++; if (qa[7] !== 1) begin failures++; $display("FAIL round_pos_half got=%0d exp=1", qa[7]); end
            checks++; if (qs[7] !== 0) begin failures++; $display("FAIL round_pos_sat got=%0d exp=0", qs[7]); end
        end
        flush();
        send(-64);
        repeat (7) send(0);
        idle(5);
        if (qa.size() == 8) begin
            checks++; if (qa[7] !== 0) begin failures++; $display("FAIL round_neg_half got=%0d exp=0", qa[7]); end
            checks++; if (qs[7] !== 0) begin failures++; $display("FAIL round_neg_sat got=%0d exp=0", qs[7]); end
        end else begin
            checks++; failures++; $display("FAIL round_neg_count got=%0d exp=8", qa.size());
        end
    endtask

    task automatic test_saturation();
        int c[8] = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
        load(c);
        flush();
        repeat (20) send(127);
        idle(5);
        checks++; if (qb.size() !== 20 || qa.size() !== 20) begin failures++; $display("FAIL sat_pos_count got=%0d/%0d exp=20", qb.size(), qa.size()); end
        if (qb.size() == 20 && qa.size() == 20) begin
            checks++; if (qb[0] !== 127 || qbs[0] !== 0) begin failures++; $display("FAIL sat_pos_edge got=%0d/%0d exp=127/0", qb[0], qbs[0]); end
            checks++; if (qb[19] !== 127) begin failures++; $display("FAIL sat_pos_out got=%0d exp=127", qb[19]); end
            checks++; if (qbs[19] !== 1) begin failures++; $display("FAIL sat_pos_flag got=%0d exp=1", qbs[19]); end
            checks++; if (qa[19] !== 60 || qs[19] !== 0) begin failures++; $display("FAIL sat_pos_unclipped got=%0d/%0d exp=60/0", qa[19], qs[19]); end
        end
        flush();
        repeat (20) send(-128);
        idle(5);
        if (qb.size() == 20 && qa.size() == 20) begin
            checks++; if (qb[0] !== -128 || qbs[0] !== 0) begin failures++; $display("FAIL sat_neg_edge got=%0d/%0d exp=-128/0", qb[0], qbs[0]); end
            checks++; if (qb[19] !== -128) begin failures++; $display("FAIL sat_neg_out got=%0d exp=-128", qb[19]); end
            checks++; if (qbs[19] !== 1) begin failures++; $display("FAIL sat_neg_flag got=%0d exp=1", qbs[19]); end
            checks++; if (qa[19] !== -60 || qs[19] !== 0) begin failures++; $display("FAIL sat_neg_unclipped got=%0d/%0d exp=-60/0", qa[19], qs[19]); end
        end else begin
            checks++; failures++; $display("FAIL sat_neg_count got=%0d/%0d exp=20", qb.size(), qa.size());
        end
    endtask

    task automatic test_gapped();
        int x[20] = '{127, -128, 50, -3, 0, 99, -77, 12, 64, -64, 1, -1, 127, 127, -128, -128, 33, -90, 5, 80};
        int bb[$];
        int cap[20];
        load(imp_c);
        flush();
        for (int i = 0; i < 20; i++) send(x[i]);
        idle(5);
        checks++; if (qa.size() !== 20) begin failures++; $display("FAIL b2b_count got=%0d exp=20", qa.size()); end
        if (qa.size() == 20)
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (qa[i] !== model(x, i)) begin failures++; $display("FAIL b2b_out[%0d] got=%0d exp=%0d", i, qa[i], model(x, i)); end
            end
        bb = qa;
        flush();
        for (int i = 0; i < 20; i++) begin
            send(x[i]);
            cap[i] = cyc;
            idle(1);
        end
        idle(5);
        checks++; if (qa.size() !== 20) begin failures++; $display("FAIL gap_count got=%0d exp=20", qa.size()); end
        if (qa.size() == 20 && bb.size() == 20)
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (qc[i] !== cap[i] + 3 || qa[i] !== bb[i])
                    begin failures++; $display("FAIL gap_out[%0d] got=%0d@%0d exp=%0d@%0d", i, qa[i], qc[i], bb[i], cap[i] + 3); end
            end
    endtask

    task automatic test_coef_clr();
        load(imp_c);
        flush();
        for (int i = 0; i < 22; i++) begin
            if (i == 18) begin coef_we = 1'b1; coef_addr = 3'd7; coef_data = 17'sd0; end
            send(100);
            coef_we = 1'b0;
        end
        checks++; if (qa.size() !== 19) begin failures++; $display("FAIL coef_count got=%0d exp=19", qa.size()); end
        if (qa.size() == 19) begin
            checks++; if (qa[15] !== 24 || qa[16] !== 24) begin failures++; $display("FAIL coef_old got=%0d,%0d exp=24,24", qa[15], qa[16]); end
            checks++; if (qa[17] !== 21 || qa[18] !== 21) begin failures++; $display("FAIL coef_new got=%0d,%0d exp=21,21", qa[17], qa[18]); end
        end
        clr = 1'b1; in_valid = 1'b1; fir_in = 8'sd100;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL clr_vld got=%0b exp=0", a_vld); end
        checks++; if (int'(a_out) !== 21) begin failures++; $display("FAIL clr_hold got=%0d exp=21", a_out); end
        clear_q();
        idle(5);
        checks++; if (qa.size() !== 0) begin failures++; $display("FAIL clr_stale got=%0d exp=0", qa.size()); end
        send(127);
        repeat (14) send(0);
        idle(5);
        checks++; if (qa.size() !== 15) begin failures++; $display("FAIL clr_coef_count got=%0d exp=15", qa.size()); end
        if (qa.size() == 15) begin
            checks++; if (qa[1] !== 0 || qa[2] !== 1) begin failures++; $display("FAIL clr_drop got=%0d,%0d exp=0,1", qa[1], qa[2]); end
            checks++; if (qa[6] !== 4 || qa[7] !== 0) begin failures++; $display("FAIL clr_coef_kept got=%0d,%0d exp=4,0", qa[6], qa[7]); end
        end
    endtask

    task automatic test_async_reset();
        load(imp_c);
        flush();
        in_valid = 1'b1; fir_in = 8'sd100;
        repeat (10) tick();
        checks++; if (a_vld !== 1'b1 || int'(a_out) == 0) begin failures++; $display("FAIL arst_pre got=%0b/%0d exp=1/nonzero", a_vld, a_out); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (a_vld !== 1'b0 || b_vld !== 1'b0) begin failures++; $display("FAIL arst_vld got=%0b/%0b exp=0/0", a_vld, b_vld); end
        checks++; if (a_out !== 8'sd0 || b_out !== 8'sd0) begin failures++; $display("FAIL arst_out got=%0d/%0d exp=0/0", a_out, b_out); end
        checks++; if (a_sat !== 1'b0 || b_sat !== 1'b0) begin failures++; $display("FAIL arst_sat got=%0b/%0b exp=0/0", a_sat, b_sat); end
        in_valid = 1'b0;
        #10 rst_n = 1'b1;
        clear_q();
        idle(6);
        checks++; if (qa.size() !== 0 || qb.size() !== 0) begin failures++; $display("FAIL arst_stale got=%0d/%0d exp=0/0", qa.size(), qb.size()); end
        repeat (15) send(100);
        idle(5);
        checks++; if (qa.size() !== 15) begin failures++; $display("FAIL arst_count got=%0d exp=15", qa.size()); end
        if (qa.size() == 15 && qb.size() == 15) begin
            checks++; if (qa[14] !== 0 || qb[14] !== 0) begin failures++; $display("FAIL arst_coef_zero got=%0d/%0d exp=0/0", qa[14], qb[14]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_gapped();
        test_coef_clr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
